// File: rtl/nd_2to1_pkg.sv
// Shared definitions for the 2-to-1 merge node: handshake levels, default widths,
// output-channel state encoding and the round-robin grant function.
package nd_2to1_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int ADDRESS_SIZE = 8;
  localparam int DATA_SIZE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
  } out_state_e;

  // A lone non-empty FIFO always wins; the round-robin pointer only breaks ties.
  function automatic logic arb_grant(input logic ne0, input logic ne1, input logic rr);
    if (ne0 && ne1) return rr;
    return ne1;
  endfunction

endpackage

// File: rtl/nd_2to1_if.sv
// 4-phase req/ack message channel carrying a destination address and a data word.
interface nd_2to1_if
  import nd_2to1_pkg::*;
#(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE
);

  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (output dst, output dat, output req, input ack);
  modport slave  (input dst, input dat, input req, output ack);

endinterface

// File: rtl/nd_fifo.sv
// Per-input message FIFO with a show-ahead read port. Full/empty come from the
// registered count, so a pop frees space only from the following cycle.
module nd_fifo
  import nd_2to1_pkg::*;
#(
  parameter int ASZ    = ADDRESS_SIZE,
  parameter int DSZ    = DATA_SIZE,
  parameter int FDEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           wr,
  input  logic [ASZ-1:0] wr_dst,
  input  logic [DSZ-1:0] wr_dat,
  input  logic           rd,
  output logic [ASZ-1:0] rd_dst,
  output logic [DSZ-1:0] rd_dat,
  output logic           full,
  output logic           empty
);

  localparam int PW = $clog2(FDEPTH);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FDEPTH);

  logic [ASZ-1:0] mem_dst [FDEPTH];
  logic [DSZ-1:0] mem_dat [FDEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [PW:0]    count;

  // Storage holds data only and is never reset.
  always_ff @(posedge i_clk) begin
    if (wr) begin
      mem_dst[wptr] <= wr_dst;
      mem_dat[wptr] <= wr_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_dst = mem_dst[rptr];
  assign rd_dat = mem_dat[rptr];
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);

endmodule

// File: rtl/nd_2to1.sv
// Two-input merge node: each input captures into its own FIFO, and a round-robin
// arbiter drains both FIFOs onto one 4-phase output channel.
module nd_2to1
  import nd_2to1_pkg::*;
#(
  parameter int ASZ    = ADDRESS_SIZE,
  parameter int DSZ    = DATA_SIZE,
  parameter int FDEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  nd_2to1_if.slave     rcv0,
  nd_2to1_if.slave     rcv1,
  nd_2to1_if.master    snd0
);

  logic           wr0, wr1, rd0, rd1;
  logic           full0, full1, empty0, empty1;
  logic [ASZ-1:0] dst0, dst1;
  logic [DSZ-1:0] dat0, dat1;
  logic           grant, load, rr;
  out_state_e     state, state_nxt;

  assign wr0 = rcv0.req && !rcv0.ack && !full0;
  assign wr1 = rcv1.req && !rcv1.ack && !full1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcv0.ack <= OFF;
    end else if (wr0) begin
      rcv0.ack <= ON;
    end else if (!rcv0.req && rcv0.ack) begin
      rcv0.ack <= OFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcv1.ack <= OFF;
    end else if (wr1) begin
      rcv1.ack <= ON;
    end else if (!rcv1.req && rcv1.ack) begin
      rcv1.ack <= OFF;
    end
  end

  nd_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FDEPTH(FDEPTH)) u_fifo0 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .wr     (wr0),
    .wr_dst (rcv0.dst),
    .wr_dat (rcv0.dat),
    .rd     (rd0),
    .rd_dst (dst0),
    .rd_dat (dat0),
    .full   (full0),
    .empty  (empty0)
  );

  nd_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FDEPTH(FDEPTH)) u_fifo1 (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .wr     (wr1),
    .wr_dst (rcv1.dst),
    .wr_dat (rcv1.dat),
    .rd     (rd1),
    .rd_dst (dst1),
    .rd_dat (dat1),
    .full   (full1),
    .empty  (empty1)
  );

  assign grant = arb_grant(!empty0, !empty1, rr);
  assign rd0   = load && !grant;
  assign rd1   = load && grant;

  // A new message is only loaded once the peer has dropped ack from the last one.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!snd0.ack && (!empty0 || !empty1)) begin
          load      = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (snd0.ack) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!snd0.ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      snd0.req <= OFF;
      snd0.dst <= '0;
      snd0.dat <= '0;
    end else begin
      state    <= state_nxt;
      snd0.req <= (state_nxt == ST_BUSY) ? ON : OFF;
      if (load) begin
        snd0.dst <= grant ? dst1 : dst0;
        snd0.dat <= grant ? dat1 : dat0;
        rr       <= ~grant;
      end
    end
  end

endmodule

// File: tb/tb_nd_2to1.sv
// Directed bench for the 2-to-1 merge node: stimulus pushes expected messages into
// a queue and a negedge monitor pops and compares each output request.
module tb_nd_2to1;
  import nd_2to1_pkg::*;

  localparam int TMO = 60;

  logic clk;
  logic rst_n;
  logic ack_en;

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;
  logic seen;
  logic [15:0] exp_q[$];

  nd_2to1_if #(.ASZ(8), .DSZ(8)) rcv0_if ();
  nd_2to1_if #(.ASZ(8), .DSZ(8)) rcv1_if ();
  nd_2to1_if #(.ASZ(8), .DSZ(8)) snd0_if ();

  nd_2to1 #(.ASZ(8), .DSZ(8), .FDEPTH(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .rcv0   (rcv0_if),
    .rcv1   (rcv1_if),
    .snd0   (snd0_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor and output peer: one comparison per request rising, ack mirrors req.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (snd0_if.req && !seen) begin
      seen = 1'b1;
      rx_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_msg", {snd0_if.dst, snd0_if.dat}, 32'hFFFF_FFFF);
      end else begin
        check("snd0_msg", {snd0_if.dst, snd0_if.dat}, exp_q.pop_front());
      end
    end else if (!snd0_if.req) begin
      seen = 1'b0;
    end
    snd0_if.ack = snd0_if.req && ack_en;
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    ack_en = 1'b0;
    rcv0_if.req = 1'b0;
    rcv1_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send0(input logic [7:0] d, input logic [7:0] a);
    int n;
    rcv0_if.dst = d;
    rcv0_if.dat = a;
    rcv0_if.req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rcv0_if.ack && n < TMO);
    check("rcv0_ack_rise", rcv0_if.ack, 1);
    rcv0_if.req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rcv0_if.ack && n < TMO);
    check("rcv0_ack_fall", rcv0_if.ack, 0);
  endtask

  task automatic send1(input logic [7:0] d, input logic [7:0] a);
    int n;
    rcv1_if.dst = d;
    rcv1_if.dat = a;
    rcv1_if.req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rcv1_if.ack && n < TMO);
    check("rcv1_ack_rise", rcv1_if.ack, 1);
    rcv1_if.req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rcv1_if.ack && n < TMO);
    check("rcv1_ack_fall", rcv1_if.ack, 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || snd0_if.req) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic blocked;
    int   rx_before;
    rst_n  = 1'b0;
    ack_en = 1'b0;
    rcv0_if.req = 1'b0; rcv0_if.dst = '0; rcv0_if.dat = '0;
    rcv1_if.req = 1'b0; rcv1_if.dst = '0; rcv1_if.dat = '0;
    #1;
    check("rst_snd0_req", snd0_if.req, 0);
    check("rst_snd0_dst", snd0_if.dst, 0);
    check("rst_snd0_dat", snd0_if.dat, 0);
    check("rst_rcv0_ack", rcv0_if.ack, 0);
    check("rst_rcv1_ack", rcv1_if.ack, 0);
    do_reset();

    // Single message: ack one edge after req, output request one edge after that.
    ack_en = 1'b1;
    exp_q.push_back({8'h05, 8'hA1});
    rcv0_if.dst = 8'h05; rcv0_if.dat = 8'hA1; rcv0_if.req = 1'b1;
    @(posedge clk); #1;
    check("t1_ack_latency", rcv0_if.ack, 1);
    check("t1_req_not_yet", snd0_if.req, 0);
    rcv0_if.req = 1'b0;
    @(posedge clk); #1;
    check("t1_snd_req_latency", snd0_if.req, 1);
    check("t1_snd_dst", snd0_if.dst, 8'h05);
    check("t1_snd_dat", snd0_if.dat, 8'hA1);
    drain("t1_drain");
    check("t1_rx_count", rx_count, 1);

    // Both inputs stream 4 messages; arbiter alternates starting with input 0.
    do_reset();
    rx_before = rx_count;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({8'h01, 8'(8'h10 + i)});
      exp_q.push_back({8'h02, 8'(8'h20 + i)});
    end
    fork
      for (int i = 0; i < 4; i++) send0(8'h01, 8'(8'h10 + i));
      for (int j = 0; j < 4; j++) send1(8'h02, 8'(8'h20 + j));
    join
    repeat (3) @(posedge clk);
    #1 ack_en = 1'b1;
    drain("t2_drain");
    check("t2_rx_count", rx_count - rx_before, 8);

    // Stalled output: 1 in the output register + 4 buffered, the 6th is held off.
    do_reset();
    rx_before = rx_count;
    for (int i = 0; i < 6; i++) exp_q.push_back({8'h03, 8'(8'h30 + i)});
    for (int i = 0; i < 5; i++) send0(8'h03, 8'(8'h30 + i));
    rcv0_if.dst = 8'h03; rcv0_if.dat = 8'h35; rcv0_if.req = 1'b1;
    blocked = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rcv0_if.ack) blocked = 1'b1;
    end
    check("t3_ack_held_off", blocked, 0);
    check("t3_rx_while_stalled", rx_count - rx_before, 1);
    ack_en = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rcv0_if.ack && n < TMO);
      check("t3_ack_after_release", rcv0_if.ack, 1);
      rcv0_if.req = 1'b0;
    end
    drain("t3_drain");
    check("t3_rx_count", rx_count - rx_before, 6);

    // Concurrent write and pop around count FDEPTH-1, across pointer wrap.
    do_reset();
    rx_before = rx_count;
    for (int i = 0; i < 12; i++) exp_q.push_back({8'h04, 8'(8'h40 + i)});
    for (int i = 0; i < 4; i++) send0(8'h04, 8'(8'h40 + i));
    ack_en = 1'b1;
    for (int i = 4; i < 12; i++) send0(8'h04, 8'(8'h40 + i));
    drain("t4_drain");
    check("t4_rx_count", rx_count - rx_before, 12);

    // Asynchronous reset while output busy and both FIFOs hold data.
    do_reset();
    exp_q.push_back({8'h06, 8'h50});
    send0(8'h06, 8'h50);
    send0(8'h06, 8'h51);
    rcv1_if.dst = 8'h07; rcv1_if.dat = 8'h60; rcv1_if.req = 1'b1;
    @(posedge clk); #1;
    check("t5_pre_snd_req", snd0_if.req, 1);
    check("t5_pre_rcv1_ack", rcv1_if.ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_snd_req", snd0_if.req, 0);
    check("t5_async_rcv1_ack", rcv1_if.ack, 0);
    check("t5_async_rcv0_ack", rcv0_if.ack, 0);
    check("t5_async_dst", snd0_if.dst, 0);
    check("t5_async_dat", snd0_if.dat, 0);
    rcv1_if.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_en = 1'b1;
    rx_before = rx_count;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_stale_msg", rx_count - rx_before, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
